// File: rtl/stub_stream_tx.sv
// Stub link transmitter: FIFO-buffered stub words sent after an all-ones start sentinel in fixed-length BX windows.
// Optional STUB_TX_TRUNC_CNT_EN adds a saturating count of truncated windows on trunc_cnt.
module stub_stream_tx #(
    parameter int WIDTH  = 36,
    parameter int DEPTH  = 64,
    parameter int BX_LEN = 108
) (
    input  logic             io_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    output logic             full,
    output logic             illegal,
    output logic             overflow,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    output logic [2:0]       bx_out,
    output logic             running
`ifdef STUB_TX_TRUNC_CNT_EN
    ,
    output logic [15:0]      trunc_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BX_LEN);
    localparam logic [WIDTH-1:0] ONES     = '1;
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0]    CYC_MAX  = CW'(BX_LEN - 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_nxt;
    logic [CW-1:0]    cyc, cyc_nxt;
    logic [2:0]       bx_nxt;
    logic             win_done, win_done_nxt;
    logic             win_started, win_started_nxt;
    logic             discard, discard_nxt;
    logic [WIDTH-1:0] tx_data_nxt;
    logic             tx_valid_nxt;
    logic             wr_ok, rd_ok, empty, trunc_evt;
    logic [WIDTH:0]   head;

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
    assign wr_ok = wr_en && !full && (wr_data != ONES);

    // A window that transmitted stubs but ended before its last one is truncated; the rest of that BX gets discarded.
    always_comb begin
        state_nxt       = state;
        cyc_nxt         = cyc;
        bx_nxt          = bx_out;
        win_done_nxt    = win_done;
        win_started_nxt = win_started;
        discard_nxt     = discard;
        tx_data_nxt     = '0;
        tx_valid_nxt    = 1'b0;
        rd_ok           = 1'b0;
        trunc_evt       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = SYNC;
                    tx_data_nxt = ONES;
                end
            end
            SYNC: begin
                state_nxt       = RUN;
                cyc_nxt         = '0;
                bx_nxt          = bx_out + 3'd1;
                win_done_nxt    = 1'b0;
                win_started_nxt = 1'b0;
            end
            RUN: begin
                if (discard) begin
                    if (!empty) begin
                        rd_ok = 1'b1;
                        if (head[WIDTH]) discard_nxt = 1'b0;
                    end
                end else if (!empty && !win_done) begin
                    rd_ok           = 1'b1;
                    tx_data_nxt     = head[WIDTH-1:0];
                    tx_valid_nxt    = 1'b1;
                    win_started_nxt = 1'b1;
                    if (head[WIDTH]) win_done_nxt = 1'b1;
                end
                if (cyc == CYC_MAX) begin
                    cyc_nxt = '0;
                    bx_nxt  = bx_out + 3'd1;
                    if (win_started_nxt && !win_done_nxt) begin
                        discard_nxt = 1'b1;
                        trunc_evt   = 1'b1;
                    end
                    win_done_nxt    = 1'b0;
                    win_started_nxt = 1'b0;
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + (AW+1)'(1);
        end else if (!wr_ok && rd_ok) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge io_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {wr_last, wr_data};
        end
    end

    always_ff @(posedge io_clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            illegal     <= 1'b0;
            overflow    <= 1'b0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            bx_out      <= 3'b111;
            running     <= 1'b0;
            cyc         <= '0;
            win_done    <= 1'b0;
            win_started <= 1'b0;
            discard     <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            full        <= (count_nxt == FULL_CNT);
            illegal     <= wr_en && (wr_data == ONES);
            tx_data     <= tx_data_nxt;
            tx_valid    <= tx_valid_nxt;
            bx_out      <= bx_nxt;
            running     <= (state_nxt == RUN);
            cyc         <= cyc_nxt;
            win_done    <= win_done_nxt;
            win_started <= win_started_nxt;
            discard     <= discard_nxt;
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && full) overflow <= 1'b1;
        end
    end

`ifdef STUB_TX_TRUNC_CNT_EN
    always_ff @(posedge io_clk) begin
        if (reset) begin
            trunc_cnt <= '0;
        end else if (trunc_evt && (trunc_cnt != 16'hFFFF)) begin
            trunc_cnt <= trunc_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/stub_stream_tx.md
Name: stub_stream_tx

Overview:
- Transmit end of the stub input link into the processing top.
- A writer pushes stub words (tagged with end-of-BX) into an internal FIFO on io_clk.
- On start, the block emits the all-ones start sentinel that the processing side uses to raise its enable, then streams stubs in fixed-length BX windows with a 3-bit BX counter.
- Used as the stimulus source in the test bench and as the link transmitter in hardware.

Parameters:
- WIDTH, 36, stub word width; sentinel = {WIDTH{1'b1}}.
- DEPTH, 64, FIFO entries; power of 2, ≥ 4.
- BX_LEN, 108, io_clk cycles per BX window; ≥ 2.

Ports:
- io_clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock io_clk.
- start  in  1  one-cycle pulse; leaves IDLE; ignored outside IDLE.
- wr_en  in  1  write strobe.
- wr_data  in  WIDTH  stub word.
- wr_last  in  1  marks the final stub of the current BX; may accompany any write.
- full  out  1  FIFO full (count == DEPTH).
- illegal  out  1  one-cycle pulse when an all-ones wr_data is dropped.
- overflow  out  1  sticky; set when a write arrives while full.
- tx_data  out  WIDTH  link word.
- tx_valid  out  1  tx_data carries a stub.
- bx_out  out  3  BX of the current window.
- running  out  1  state == RUN.

Behaviour:
- All outputs registered.
- Reset: state IDLE, FIFO empty, tx_data=0, tx_valid=0, bx_out=3'b111, overflow=0, illegal=0, cycle counter 0, discard flag 0.
- Reset mid-operation behaves the same: FIFO contents are lost and the next transmission needs a new start.

Write side:
- Write accepted iff wr_en && !full && wr_data != all-ones. The stored entry is {wr_last, wr_data}.
- all-ones wr_data: dropped; illegal pulses next cycle; its wr_last is also lost.
- Write while full: rejected even if a read occurs in the same cycle; overflow set until reset.
- Simultaneous accepted write and read: count unchanged.

FSM:
- IDLE: tx_data=0, tx_valid=0. FIFO accepts writes. start → SYNC.
- SYNC: one cycle; tx_data=all-ones, tx_valid=0 (registered, visible the cycle after start). Next state RUN, cycle counter=0, bx_out increments (0 for the first window).
- RUN, per cycle with counter c (0..BX_LEN-1):
  - If not discarding, FIFO non-empty, and this window's last entry not yet sent: pop, tx_data=entry data, tx_valid=1. If the entry has last=1, mark the window done.
  - Otherwise: tx_data=0, tx_valid=0 (null word). An empty FIFO mid-window just produces nulls.
  - Discarding: pop entries without transmitting until a last=1 entry is popped (that entry is also discarded), then clear the discard flag. While discarding, the block outputs nulls.
  - At c == BX_LEN-1:
    - Counter wraps to 0 and bx_out increments mod 8 (7→0).
    - The window-done mark clears.
    - If the window ended before its last entry was sent, set the discard flag. Truncation: the remainder of that BX is never transmitted.
  - A stub popped in cycle BX_LEN-1 still belongs to the old window.
- RUN never exits except by reset.

Latency:
- Write to earliest tx appearance: 2 cycles (FIFO write, registered pop/output) when the window is open.

Optional Feature:
- Macro STUB_TX_TRUNC_CNT_EN.
- Defined: adds output port trunc_cnt [15:0]. It increments (saturating at 16'hFFFF) once per window whose end sets the discard flag, and resets to 0.
- Undefined: port and counter absent; truncation behaviour otherwise identical.

Test Plan:
- Reset, then start with FIFO empty → tx_data=36'hFFFFFFFFF for exactly 1 cycle, then bx_out=0, running=1, and nulls; bx_out reaches 1 after 108 cycles and wraps 7→0 after 8 windows.
- Preload 3 stubs (0x1, 0x2, 0x3 with last on 0x3), then start → after sentinel, tx_valid=1 for 0x1, 0x2, 0x3 in cycles c=0..2 of BX 0, then nulls to c=107.
- Load BX0 with 120 stubs (last on #120), with DEPTH kept fed → 108 transmitted in BX0, #109–#120 discarded; BX1 begins with its first stub after discard. With the macro defined, trunc_cnt=1.
- Write 65 words with no reads in IDLE → full=1 after 64; 65th rejected; overflow=1 and stays 1 until reset.
- Write 36'hFFFFFFFFF → illegal pulses once, count unchanged, no sentinel appears mid-RUN.
- Assert reset at c=50 of BX 2 with 10 entries queued → next cycle: tx_valid=0, bx_out=7, FIFO empty, state IDLE; start is required to resume.
